busca_instrucao: RTL

- Instruction-fetch stage directly upstream of the program memory.
- Owns the fetch PC and drives the memory read address.
- Captures the byte the memory returns one cycle later and buffers it in a small prefetch FIFO.
- Presents fetched bytes to decode through a valid/ready handshake; a branch (desvio) flushes all speculative fetches and redirects the PC.

---
 rtl/busca_instrucao_if.sv | 25 ++
 rtl/busca_instrucao.sv | 114 +++++++++++
 2 files changed

// File: rtl/busca_instrucao_if.sv
// Fetch-stage bus: program-memory read port plus the valid/ready instruction stream to decode.
// master = fetch stage, slave = memory/decode side.
interface busca_instrucao_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  desvio;
  logic [ADDR_WIDTH-1:0] desvio_addr;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;

  modport master (
    output mem_addr, instr, instr_pc, instr_valid,
    input  mem_data, desvio, desvio_addr, instr_ready
  );

  modport slave (
    input  mem_addr, instr, instr_pc, instr_valid,
    output mem_data, desvio, desvio_addr, instr_ready
  );
endinterface

// File: rtl/busca_instrucao.sv
// Instruction fetch: owns the fetch PC, reads a byte per cycle and queues it in a prefetch FIFO.
// Optional macro BUSCA_BYPASS_EN forwards a return straight to decode when the FIFO is empty.
module busca_instrucao #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input logic                 clock,
  input logic                 reset_n,
  busca_instrucao_if.master   bus_io
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] infl_pc_q, infl_pc_d;
  logic                  infl_q, infl_d;
  logic                  run_q;
  logic [PtrW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [PtrW:0]         cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] tag_q  [FIFO_DEPTH];

  logic head_valid, byp_valid, pop, byp_take, push, wr_en, issue;

  always_comb begin
    head_valid = (cnt_q != '0);
`ifdef BUSCA_BYPASS_EN
    byp_valid = !head_valid && infl_q && !bus_io.desvio;
`else
    byp_valid = 1'b0;
`endif
    pop      = head_valid && bus_io.instr_ready;
    byp_take = byp_valid && bus_io.instr_ready;
    push     = infl_q && !byp_take;
    wr_en    = push && !bus_io.desvio;
    // run_q keeps the first edge after an asynchronous release from also issuing a read
    issue    = run_q && !bus_io.desvio && ((32'(cnt_q) + 32'(infl_q)) < FIFO_DEPTH);

    bus_io.mem_addr    = pc_q;
    bus_io.instr_valid = head_valid || byp_valid;
    if (head_valid) begin
      bus_io.instr    = data_q[rd_q];
      bus_io.instr_pc = tag_q[rd_q];
    end else if (byp_valid) begin
      bus_io.instr    = bus_io.mem_data;
      bus_io.instr_pc = infl_pc_q;
    end else begin
      bus_io.instr    = '0;
      bus_io.instr_pc = '0;
    end
  end

  always_comb begin
    pc_d      = pc_q;
    infl_d    = infl_q;
    infl_pc_d = infl_pc_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    if (bus_io.desvio) begin
      // Flush wins over issue and capture; any in-flight return is dropped
      pc_d   = bus_io.desvio_addr;
      infl_d = 1'b0;
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
    end else begin
      infl_d = issue;
      if (issue) begin
        pc_d      = pc_q + ADDR_WIDTH'(1);
        infl_pc_d = pc_q;
      end
      if (wr_en) wr_d = wr_q + PtrW'(1);
      if (pop)   rd_d = rd_q + PtrW'(1);
      if (wr_en && !pop) begin
        cnt_d = cnt_q + (PtrW+1)'(1);
      end else if (pop && !wr_en) begin
        cnt_d = cnt_q - (PtrW+1)'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_ADDR;
      infl_pc_q <= '0;
      infl_q    <= 1'b0;
      run_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      infl_pc_q <= infl_pc_d;
      infl_q    <= infl_d;
      run_q     <= 1'b1;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible through cnt_q
  always_ff @(posedge clock) begin
    if (wr_en) begin
      data_q[wr_q] <= bus_io.mem_data;
      tag_q[wr_q]  <= infl_pc_q;
    end
  end

endmodule
